mem_bus_ctrl: RTL and testbench

- Parametrised successor to the single-cycle data-memory address decoder and read-data mux in the processor top level.
- Sits between the ARM core's data port and NSLAVES memory-mapped slaves: dmem, mouse_mem, sprite_mem, and future peripherals.
- Decodes each access to one slave and drives a one-hot enable for that slave.
- Inserts per-slave programmable wait states, registers the selected read data, and returns a ready handshake to the core.

---
 rtl/mem_bus_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: data-memory bus controller between the core data port and NSLAVES
// memory-mapped slaves. Decodes each access to one slave, drives a one-hot enable for
// WAIT_CFG[sel]+1 cycles, registers the selected read data and returns a one-cycle
// cpu_ready pulse.
//
// Optional feature macro: MEM_BUS_ERR_EN
//   defined   : unmapped accesses raise cpu_err together with cpu_ready.
//   undefined : cpu_err is tied to 0; unmapped accesses still complete silently.
//
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   cpu_req/we      core request and direction (1 = write)
//   cpu_addr/wdata  core byte address and write data
//   cpu_rdata       registered read data, valid while cpu_ready
//   cpu_ready       one-cycle completion pulse
//   cpu_err         unmapped-access flag (see macro above)
//   busy            high whenever the controller is not idle
//   s_en            one-hot slave enable
//   s_we            slave write enable
//   s_addr/s_wdata  latched address/write data to slaves
//   s_rdata         concatenated slave read data, slave i at [DW*i +: DW]
module mem_bus_ctrl #(
    parameter int unsigned          NSLAVES  = 4,
    parameter int unsigned          DW       = 32,
    parameter int unsigned          AW       = 32,
    parameter int unsigned          SEL_LO   = 12,
    parameter logic [4*NSLAVES-1:0] WAIT_CFG = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [AW-1:0]         cpu_addr,
    input  logic [DW-1:0]         cpu_wdata,
    output logic [DW-1:0]         cpu_rdata,
    output logic                  cpu_ready,
    output logic                  cpu_err,
    output logic                  busy,
    output logic [NSLAVES-1:0]    s_en,
    output logic                  s_we,
    output logic [AW-1:0]         s_addr,
    output logic [DW-1:0]         s_wdata,
    input  logic [NSLAVES*DW-1:0] s_rdata
);

    localparam int unsigned SELW = $clog2(NSLAVES);
    localparam int unsigned TOP  = SEL_LO + SELW;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e              state_q;
    logic [SELW-1:0]     sel_q;
    logic [3:0]          cnt_q;
    logic [NSLAVES-1:0]  s_en_q;
    logic                s_we_q;
    logic [AW-1:0]       s_addr_q;
    logic [DW-1:0]       s_wdata_q;
    logic [DW-1:0]       cpu_rdata_q;
    logic                cpu_ready_q;
    logic                busy_q;

    logic [SELW-1:0]     sel;
    logic                mapped;
    logic [NSLAVES-1:0]  en_dec;
    logic [3:0]          wait_sel;
    logic [DW-1:0]       rdata_sel;

    assign sel    = cpu_addr[SEL_LO +: SELW];
    // Everything above the select field must be zero; if the field reaches the top
    // of the address the shift yields zero and every address is mapped.
    assign mapped = ((cpu_addr >> TOP) == '0);

    // Decode from the live address (used in idle) and mux read data from the
    // latched select (used in access), so a moving cpu_addr cannot redirect it.
    always_comb begin
        en_dec    = '0;
        wait_sel  = '0;
        rdata_sel = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (sel == SELW'(i)) begin
                en_dec[i] = 1'b1;
                wait_sel  = WAIT_CFG[4*i +: 4];
            end
            if (sel_q == SELW'(i)) begin
                rdata_sel = s_rdata[DW*i +: DW];
            end
        end
    end

`ifdef MEM_BUS_ERR_EN
    logic cpu_err_q;
    assign cpu_err = cpu_err_q;
`else
    assign cpu_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            cnt_q       <= '0;
            s_en_q      <= '0;
            s_we_q      <= 1'b0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MEM_BUS_ERR_EN
            cpu_err_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cpu_req) begin
                        s_addr_q  <= cpu_addr;
                        s_wdata_q <= cpu_wdata;
                        sel_q     <= sel;
                        busy_q    <= 1'b1;
                        if (mapped) begin
                            s_we_q  <= cpu_we;
                            s_en_q  <= en_dec;
                            cnt_q   <= wait_sel;
                            state_q <= StAccess;
                        end else begin
                            // No slave sees an unmapped access; complete it at once.
                            s_we_q      <= 1'b0;
                            cpu_ready_q <= 1'b1;
`ifdef MEM_BUS_ERR_EN
                            cpu_err_q   <= 1'b1;
                            cpu_rdata_q <= '0;
`else
                            if (!cpu_we) begin
                                cpu_rdata_q <= '0;
                            end
`endif
                            state_q     <= StResp;
                        end
                    end
                end
                StAccess: begin
                    if (cnt_q == 4'd0) begin
                        if (!s_we_q) begin
                            cpu_rdata_q <= rdata_sel;
                        end
                        s_en_q      <= '0;
                        s_we_q      <= 1'b0;
                        cpu_ready_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    cpu_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
`ifdef MEM_BUS_ERR_EN
                    cpu_err_q   <= 1'b0;
`endif
                    state_q     <= StIdle;
                end
                default: begin
                    s_en_q      <= '0;
                    s_we_q      <= 1'b0;
                    cpu_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign s_en      = s_en_q;
    assign s_we      = s_we_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;

    localparam int unsigned NSLAVES = 4;
    localparam int unsigned DW      = 32;
    localparam int unsigned AW      = 32;
    // slave0=0, slave1=3, slave2=0, slave3=15 wait states
    localparam logic [4*NSLAVES-1:0] WAIT_CFG = 16'hF030;

`ifdef MEM_BUS_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cpu_req;
    logic                  cpu_we;
    logic [AW-1:0]         cpu_addr;
    logic [DW-1:0]         cpu_wdata;
    logic [DW-1:0]         cpu_rdata;
    logic                  cpu_ready;
    logic                  cpu_err;
    logic                  busy;
    logic [NSLAVES-1:0]    s_en;
    logic                  s_we;
    logic [AW-1:0]         s_addr;
    logic [DW-1:0]         s_wdata;
    logic [NSLAVES*DW-1:0] s_rdata;

    int checks = 0;
    int errors = 0;

    mem_bus_ctrl #(
        .NSLAVES  (NSLAVES),
        .DW       (DW),
        .AW       (AW),
        .SEL_LO   (12),
        .WAIT_CFG (WAIT_CFG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .busy      (busy),
        .s_en      (s_en),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_rdata   (s_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        s_rdata   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h1234_5678};

        // Reset state
        tick();
        tick();
        chk("rst_s_en", 64'(s_en), 64'h0);
        chk("rst_ready", 64'(cpu_ready), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_rdata", 64'(cpu_rdata), 64'h0);
        chk("rst_s_addr", 64'(s_addr), 64'h0);
        chk("rst_err", 64'(cpu_err), 64'h0);
        reset = 1'b1;
        tick();

        // Read slave0, W=0
        cpu_addr = 32'h0000_0010;
        cpu_we   = 1'b0;
        cpu_req  = 1'b1;
        tick();
        chk("rd0_s_en", 64'(s_en), 64'h1);
        chk("rd0_busy", 64'(busy), 64'h1);
        chk("rd0_ready_early", 64'(cpu_ready), 64'h0);
        tick();
        chk("rd0_s_en_off", 64'(s_en), 64'h0);
        chk("rd0_ready", 64'(cpu_ready), 64'h1);
        chk("rd0_rdata", 64'(cpu_rdata), 64'h1234_5678);
        cpu_req = 1'b0;
        tick();
        chk("rd0_ready_pulse", 64'(cpu_ready), 64'h0);
        chk("rd0_idle", 64'(busy), 64'h0);

        // Write slave1, W=3: s_en/s_we held 4 cycles
        cpu_addr  = 32'h0000_1004;
        cpu_wdata = 32'hA5A5_A5A5;
        cpu_we    = 1'b1;
        cpu_req   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("wr1_s_en", 64'(s_en), 64'h2);
            chk("wr1_s_we", 64'(s_we), 64'h1);
            chk("wr1_ready_early", 64'(cpu_ready), 64'h0);
        end
        chk("wr1_s_wdata", 64'(s_wdata), 64'hA5A5_A5A5);
        chk("wr1_s_addr", 64'(s_addr), 64'h1004);
        tick();
        chk("wr1_s_en_off", 64'(s_en), 64'h0);
        chk("wr1_s_we_off", 64'(s_we), 64'h0);
        chk("wr1_ready", 64'(cpu_ready), 64'h1);
        chk("wr1_rdata_kept", 64'(cpu_rdata), 64'h1234_5678);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        tick();

        // Back-to-back reads slave2 then slave3 with cpu_req held high
        cpu_addr = 32'h0000_2000;
        cpu_req  = 1'b1;
        tick();
        chk("b2b_first_s_en", 64'(s_en), 64'h4);
        tick();
        chk("b2b_first_ready", 64'(cpu_ready), 64'h1);
        chk("b2b_first_rdata", 64'(cpu_rdata), 64'h2222_2222);
        cpu_addr = 32'h0000_3000;
        tick();
        chk("b2b_resp_no_accept", 64'(s_en), 64'h0);
        chk("b2b_idle_busy", 64'(busy), 64'h0);
        tick();
        // Second access starts 3 cycles after the first; slave3 has W=15
        chk("b2b_second_s_en", 64'(s_en), 64'h8);
        cpu_addr = 32'h0000_1000;
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("b2b_s_en_hold", 64'(s_en), 64'h8);
            chk("b2b_busy_hold", 64'(busy), 64'h1);
            chk("b2b_ready_early", 64'(cpu_ready), 64'h0);
        end
        chk("b2b_s_addr_latched", 64'(s_addr), 64'h3000);
        tick();
        // 17th busy cycle carries cpu_ready
        chk("w15_ready", 64'(cpu_ready), 64'h1);
        chk("w15_busy", 64'(busy), 64'h1);
        chk("w15_rdata_latched_sel", 64'(cpu_rdata), 64'h3333_3333);
        chk("w15_s_en_off", 64'(s_en), 64'h0);
        cpu_req = 1'b0;
        tick();
        chk("w15_busy_off", 64'(busy), 64'h0);
        chk("w15_ready_off", 64'(cpu_ready), 64'h0);

        // Reset mid-ACCESS on slave1 (W=3)
        cpu_addr = 32'h0000_1000;
        cpu_req  = 1'b1;
        tick();
        chk("abort_s_en", 64'(s_en), 64'h2);
        tick();
        reset = 1'b0;
        tick();
        chk("abort_s_en_rst", 64'(s_en), 64'h0);
        chk("abort_busy_rst", 64'(busy), 64'h0);
        chk("abort_rdata_rst", 64'(cpu_rdata), 64'h0);
        chk("abort_s_addr_rst", 64'(s_addr), 64'h0);
        cpu_req = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("abort_no_ready", 64'(cpu_ready), 64'h0);
            chk("abort_no_s_en", 64'(s_en), 64'h0);
        end

        // Preload cpu_rdata, then unmapped read
        cpu_addr = 32'h0000_0000;
        cpu_req  = 1'b1;
        tick();
        tick();
        chk("pre_rdata", 64'(cpu_rdata), 64'h1234_5678);
        cpu_req = 1'b0;
        tick();
        cpu_addr = 32'h0001_0000;
        cpu_req  = 1'b1;
        tick();
        chk("unm_ready", 64'(cpu_ready), 64'h1);
        chk("unm_err", 64'(cpu_err), 64'(ERR_EXP));
        chk("unm_rdata", 64'(cpu_rdata), 64'h0);
        chk("unm_s_en", 64'(s_en), 64'h0);
        cpu_req = 1'b0;
        tick();
        chk("unm_ready_off", 64'(cpu_ready), 64'h0);
        chk("unm_err_off", 64'(cpu_err), 64'h0);
        chk("unm_s_en_off", 64'(s_en), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
